// File: rtl/final_design_pkg.sv
// Shared types and command-word layout for the TPU matrix-multiply core.
package final_design_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        COMPUTE = 3'd2,
        WRITE   = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int RST_BIT   = 0;
    localparam int START_BIT = 1;
    localparam int ACK_BIT   = 2;
    localparam int RSV_BIT   = 3;
    localparam int OPC_LSB   = 4;
    localparam int B_LSB     = 8;
    localparam int A_LSB     = 16;
    localparam int N_LSB     = 24;

    localparam logic [3:0] OP_MATMUL = 4'hA;

    function automatic logic [7:0] clamp_dim(input logic [7:0] n, input logic [7:0] max_n);
        return (n > max_n) ? max_n : n;
    endfunction

endpackage

// File: rtl/final_design_pe.sv
// One processing element: forwards a right and b down, accumulates a*b unsigned.
module tpu_pe
    import final_design_pkg::*;
#(
    parameter int Data_Width = 8,
    parameter int ACC_W      = 19
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [Data_Width-1:0] a_in,
    input  logic [Data_Width-1:0] b_in,
    output logic [Data_Width-1:0] a_out,
    output logic [Data_Width-1:0] b_out,
    output logic [ACC_W-1:0]      acc
);

    logic [2*Data_Width-1:0] prod_s;

    assign prod_s = a_in * b_in;

    // Operand pass-through and multiply-accumulate, cleared synchronously.
    always_ff @(posedge clk) begin
        if (clr) begin
            a_out <= '0;
            b_out <= '0;
            acc   <= '0;
        end else begin
            a_out <= a_in;
            b_out <= b_in;
            acc   <= acc + ACC_W'(prod_s);
        end
    end

endmodule

// File: rtl/final_design.sv
// TPU core: loads A and B from the operand RAM, multiplies them on an
// output-stationary systolic grid and writes C into c_mem.
module final_design
    import final_design_pkg::*;
#(
    parameter int Matrix_Size = 8,
    parameter int Data_Width  = 8,
    parameter int ACC_W       = 2*Data_Width + $clog2(Matrix_Size)
) (
    input  logic        CLOCK,
    input  logic [31:0] control_to_FPGA,
    output logic        control_to_HPS
);

    localparam int M     = Matrix_Size;
    localparam int IDX_W = $clog2(M);
    localparam int N_W   = $clog2(M + 1);
    localparam int T_W   = $clog2(3*M) + 1;
    localparam int C_W   = $clog2(M*M);

    // Operand RAM contents are preloaded from outside; the core only reads it.
    logic [Data_Width-1:0] opnd_mem [256];
    logic [ACC_W-1:0]      c_mem    [M*M];

    logic [Data_Width-1:0] a_buf_r  [M][M];
    logic [Data_Width-1:0] b_buf_r  [M][M];
    logic [Data_Width-1:0] a_edge_r [M];
    logic [Data_Width-1:0] b_edge_r [M];
    logic [Data_Width-1:0] a_pass_s [M][M];
    logic [Data_Width-1:0] b_pass_s [M][M];
    logic [ACC_W-1:0]      acc_s    [M][M];

    state_t         state_r, state_s;
    logic [N_W-1:0] n_r, row_r, col_r, n_launch_s;
    logic [7:0]     ptr_r, b_base_r;
    logic           phase_r, done_r;
    logic [T_W-1:0] t_r;
    logic [C_W-1:0] widx_r;

    logic rst_s, start_s, ack_s, valid_op_s, last_col_s, last_row_s, t_last_s, pe_clr_s;
    logic rsv_unused_s;

    assign rst_s        = control_to_FPGA[RST_BIT];
    assign start_s      = control_to_FPGA[START_BIT];
    assign ack_s        = control_to_FPGA[ACK_BIT];
    assign rsv_unused_s = control_to_FPGA[RSV_BIT];
    assign n_launch_s   = N_W'(clamp_dim(control_to_FPGA[N_LSB +: 8], 8'(M)));
    assign valid_op_s   = (control_to_FPGA[OPC_LSB +: 4] == OP_MATMUL) && (n_launch_s != '0);
    assign last_col_s   = (col_r == n_r - N_W'(1));
    assign last_row_s   = (row_r == n_r - N_W'(1));
    assign t_last_s     = (t_r == T_W'(3*M - 1));
    assign pe_clr_s     = rst_s || ((state_r == COMPUTE) && (t_r == '0));
    assign control_to_HPS = done_r;

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) begin
                    state_s = valid_op_s ? LOAD : DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (phase_r && last_row_s && last_col_s) begin
                    state_s = COMPUTE;
                end else begin
                    state_s = LOAD;
                end
            end
            COMPUTE: begin
                if (t_last_s) begin
                    state_s = WRITE;
                end else begin
                    state_s = COMPUTE;
                end
            end
            WRITE: begin
                if (last_row_s && last_col_s) begin
                    state_s = DONE;
                end else begin
                    state_s = WRITE;
                end
            end
            DONE: begin
                if (ack_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register, job fields and the row/column walk shared by LOAD and WRITE.
    always_ff @(posedge CLOCK) begin
        if (rst_s) begin
            state_r  <= IDLE;
            done_r   <= 1'b0;
            n_r      <= '0;
            row_r    <= '0;
            col_r    <= '0;
            ptr_r    <= 8'd0;
            b_base_r <= 8'd0;
            phase_r  <= 1'b0;
            t_r      <= '0;
            widx_r   <= '0;
        end else begin
            state_r <= state_s;
            done_r  <= (state_s == DONE);
            case (state_r)
                IDLE: begin
                    n_r      <= n_launch_s;
                    ptr_r    <= control_to_FPGA[A_LSB +: 8];
                    b_base_r <= control_to_FPGA[B_LSB +: 8];
                    row_r    <= '0;
                    col_r    <= '0;
                    phase_r  <= 1'b0;
                    t_r      <= '0;
                end
                LOAD: begin
                    ptr_r <= ptr_r + 8'd1;
                    if (last_col_s) begin
                        col_r <= '0;
                        if (last_row_s) begin
                            row_r   <= '0;
                            phase_r <= 1'b1;
                            ptr_r   <= b_base_r;
                        end else begin
                            row_r <= row_r + N_W'(1);
                        end
                    end else begin
                        col_r <= col_r + N_W'(1);
                    end
                end
                COMPUTE: begin
                    t_r    <= t_r + T_W'(1);
                    row_r  <= '0;
                    col_r  <= '0;
                    widx_r <= '0;
                end
                WRITE: begin
                    widx_r <= widx_r + C_W'(1);
                    if (last_col_s) begin
                        col_r <= '0;
                        row_r <= row_r + N_W'(1);
                    end else begin
                        col_r <= col_r + N_W'(1);
                    end
                end
                default: begin
                    t_r <= '0;
                end
            endcase
        end
    end

    // Operand buffers: cleared at launch so rows/cols beyond N stay zero.
    always_ff @(posedge CLOCK) begin
        if (rst_s || ((state_r == IDLE) && (state_s == LOAD))) begin
            for (int i = 0; i < M; i++) begin
                for (int j = 0; j < M; j++) begin
                    a_buf_r[i][j] <= '0;
                    b_buf_r[i][j] <= '0;
                end
            end
        end else if (state_r == LOAD) begin
            if (phase_r) begin
                b_buf_r[row_r[IDX_W-1:0]][col_r[IDX_W-1:0]] <= opnd_mem[ptr_r];
            end else begin
                a_buf_r[row_r[IDX_W-1:0]][col_r[IDX_W-1:0]] <= opnd_mem[ptr_r];
            end
        end
    end

    // Skewed edge feed: row/column g enters the grid g cycles later than row/column 0.
    always_ff @(posedge CLOCK) begin
        for (int g = 0; g < M; g++) begin
            if (rst_s || (state_r != COMPUTE)) begin
                a_edge_r[g] <= '0;
                b_edge_r[g] <= '0;
            end else if ((t_r >= T_W'(g + 1)) && (t_r < T_W'(g + 1 + M))) begin
                a_edge_r[g] <= a_buf_r[g][IDX_W'(t_r - T_W'(g + 1))];
                b_edge_r[g] <= b_buf_r[IDX_W'(t_r - T_W'(g + 1))][g];
            end else begin
                a_edge_r[g] <= '0;
                b_edge_r[g] <= '0;
            end
        end
    end

    // Result write-back; c_mem deliberately survives reset.
    always_ff @(posedge CLOCK) begin
        if (!rst_s && (state_r == WRITE)) begin
            c_mem[widx_r] <= acc_s[row_r[IDX_W-1:0]][col_r[IDX_W-1:0]];
        end
    end

    for (genvar gi = 0; gi < M; gi++) begin : g_row
        for (genvar gj = 0; gj < M; gj++) begin : g_col
            logic [Data_Width-1:0] a_in_s, b_in_s;
            if (gj == 0) begin : g_a_edge
                assign a_in_s = a_edge_r[gi];
            end else begin : g_a_pass
                assign a_in_s = a_pass_s[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign b_in_s = b_edge_r[gj];
            end else begin : g_b_pass
                assign b_in_s = b_pass_s[gi-1][gj];
            end
            tpu_pe #(
                .Data_Width(Data_Width),
                .ACC_W     (ACC_W)
            ) u_pe (
                .clk  (CLOCK),
                .clr  (pe_clr_s),
                .a_in (a_in_s),
                .b_in (b_in_s),
                .a_out(a_pass_s[gi][gj]),
                .b_out(b_pass_s[gi][gj]),
                .acc  (acc_s[gi][gj])
            );
        end
    end

endmodule

// File: tb/tb_final_design.sv
// Scoreboard bench for final_design: a reference matmul model queues expected C values per job.
module tb_final_design;
    import final_design_pkg::*;

    logic        clk = 1'b0;
    logic [31:0] word;
    logic        done;

    int n_checks = 0;
    int n_pass   = 0;
    int exp_q[$];
    int tb_mem[256];
    int tb_c[64];
    int lat1, cnt;

    always #5 clk = ~clk;

    final_design #(.Matrix_Size(8), .Data_Width(8)) dut (
        .CLOCK          (clk),
        .control_to_FPGA(word),
        .control_to_HPS (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic set_mem(input int a, input int v);
        tb_mem[a & 255] = v & 255;
        dut.opnd_mem[a & 255] = 8'(v);
    endtask

    function automatic int dim_of(input logic [31:0] w);
        int n;
        n = int'(w[31:24]);
        return (n > 8) ? 8 : n;
    endfunction

    // Reference model: push every C(i,j) of a valid job in write order.
    task automatic push_job(input logic [31:0] w);
        int n, ab, bb, s;
        n  = dim_of(w);
        ab = int'(w[23:16]);
        bb = int'(w[15:8]);
        if (w[7:4] == 4'hA && n != 0) begin
            for (int i = 0; i < n; i++) begin
                for (int j = 0; j < n; j++) begin
                    s = 0;
                    for (int k = 0; k < n; k++)
                        s += tb_mem[(ab + i*n + k) & 255] * tb_mem[(bb + k*n + j) & 255];
                    s &= 32'h7FFFF;
                    tb_c[i*n + j] = s;
                    exp_q.push_back(s);
                end
            end
        end
    endtask

    task automatic wait_done(input int limit, output int c);
        c = 0;
        while (done !== 1'b1 && c < limit) begin
            tick();
            c++;
        end
        check("done_rise", done, 1);
    endtask

    // Pop the job's expectations and confirm the rest of c_mem is untouched.
    task automatic drain(input int n);
        for (int idx = 0; idx < 64; idx++) begin
            if (idx < n*n && exp_q.size() > 0)
                check("c_mem", dut.c_mem[idx], exp_q.pop_front());
            else
                check("c_mem_untouched", dut.c_mem[idx], tb_c[idx]);
        end
    endtask

    task automatic do_reset(input int cycles);
        word = 32'h0000_0001;
        repeat (cycles) tick();
        word = 32'h0000_0000;
        check("reset_done_low", done, 0);
        check("reset_fsm_idle", int'(dut.state_r), int'(IDLE));
    endtask

    task automatic run_job(input logic [31:0] w, output int c);
        push_job(w);
        word = w;
        wait_done(2000, c);
    endtask

    initial begin
        word = 32'h0000_0001;
        tick();
        do_reset(2);

        // 1) identity x ramp
        for (int a = 0; a < 256; a++) set_mem(a, $urandom_range(0, 255));
        for (int i = 0; i < 8; i++)
            for (int k = 0; k < 8; k++) begin
                set_mem(i*8 + k, (i == k) ? 1 : 0);
                set_mem(64 + i*8 + k, 8*i + k);
            end
        run_job(32'h0800_40A2, lat1);
        check("latency_window", (lat1 >= 216 && lat1 <= 220), 1);
        for (int idx = 0; idx < 64; idx++) check("ident_ramp", dut.c_mem[idx], idx);
        drain(8);

        // 2) handshake and level-sensitive restart
        repeat (3) tick();
        check("done_hold", done, 1);
        push_job(32'h0800_40A2);
        word = 32'h0800_40A6;
        tick();
        check("done_fall", done, 0);
        word = 32'h0800_40A2;
        wait_done(2000, cnt);
        check("latency_rerun", cnt, lat1);
        drain(8);

        // 3) reset then identical rerun
        do_reset(2);
        run_job(32'h0800_40A2, cnt);
        check("latency_after_reset", cnt, lat1);
        drain(8);
        do_reset(1);

        // 4) full-scale operands, no wrap in 19 bits
        for (int a = 0; a < 128; a++) set_mem(a, 255);
        run_job(32'h0800_40A2, cnt);
        check("overflow_const", dut.c_mem[63], 520200);
        drain(8);
        do_reset(1);

        // 5) N=3 partial job, then an unsupported opcode
        for (int a = 0; a < 9; a++) begin
            set_mem(8'h10 + a, 2);
            set_mem(8'h30 + a, 3);
        end
        run_job(32'h0310_30A2, cnt);
        check("n3_const", dut.c_mem[8], 18);
        drain(3);
        do_reset(1);
        run_job(32'h0800_4002, cnt);
        check("bad_op_within_2", (cnt <= 2), 1);
        drain(0);
        do_reset(1);

        // 6) reset mid-LOAD and mid-COMPUTE abort the job
        word = 32'h0800_40A2;
        repeat (50) tick();
        do_reset(1);
        repeat (300) tick();
        check("abort_load_no_done", done, 0);
        word = 32'h0800_40A2;
        repeat (140) tick();
        check("in_compute", int'(dut.state_r), int'(COMPUTE));
        do_reset(1);
        repeat (300) tick();
        check("abort_compute_no_done", done, 0);
        drain(0);

        // wrapped B address and clamped N
        run_job(32'h0800_E0A2, cnt);
        check("latency_wrap", cnt, lat1);
        drain(8);
        do_reset(1);
        run_job(32'h0C00_40A2, cnt);
        check("latency_clamp", cnt, lat1);
        drain(8);
        do_reset(1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
